// File: rtl/wb_port_scheduler_pkg.sv
// Shared constants and types for the writeback commit-port scheduler.
// The widths of id_t and wb_grant_t match the default scheduler configuration.
package wb_port_scheduler_pkg;

    localparam int unsigned WB_SCHED_UNITS        = 4;
    localparam int unsigned WB_SCHED_PORTS        = 2;
    localparam int unsigned WB_SCHED_STARVE_LIMIT = 7;
    localparam int unsigned WB_ID_W               = 3;

    typedef logic [WB_ID_W-1:0] id_t;

    typedef struct packed {
        logic                              valid;
        logic [$clog2(WB_SCHED_UNITS)-1:0] unit_sel;
        id_t                               id;
    } wb_grant_t;

    // Index that follows idx in a ring of n entries.
    function automatic int unsigned next_unit(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wb_port_scheduler_rotate_select.sv
// Combinational rotating multi-grant selector: units are scanned from ptr
// upward (with wrap), and each requesting unit takes the lowest free port in port_mask.
module wb_rotate_select #(
    parameter  int unsigned NUM_UNITS = 4,
    parameter  int unsigned NUM_PORTS = 2,
    localparam int unsigned SEL_W     = $clog2(NUM_UNITS)
) (
    input  logic [NUM_UNITS-1:0]            req,
    input  logic [SEL_W-1:0]                ptr,
    input  logic [NUM_PORTS-1:0]            port_mask,
    output logic [NUM_UNITS-1:0]            grant,
    output logic [NUM_PORTS-1:0]            port_valid,
    output logic [NUM_PORTS-1:0][SEL_W-1:0] port_sel,
    output logic                            any_grant,
    output logic [SEL_W-1:0]                last_unit
);

    always_comb begin
        logic [NUM_PORTS-1:0] free;
        int unsigned          u;
        logic                 placed;

        free       = port_mask;
        grant      = '0;
        port_valid = '0;
        port_sel   = '0;
        any_grant  = 1'b0;
        last_unit  = '0;
        u          = 0;
        placed     = 1'b0;

        for (int unsigned k = 0; k < NUM_UNITS; k++) begin
            u = 32'(ptr) + k;
            if (u >= NUM_UNITS) begin
                u = u - NUM_UNITS;
            end
            placed = 1'b0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (req[u] && !placed && free[p]) begin
                    free[p]       = 1'b0;
                    placed        = 1'b1;
                    port_valid[p] = 1'b1;
                    port_sel[p]   = SEL_W'(u);
                    grant[u]      = 1'b1;
                    any_grant     = 1'b1;
                    last_unit     = SEL_W'(u);
                end
            end
        end
    end

endmodule

// File: rtl/wb_port_scheduler.sv
// Fair writeback scheduler for shared commit ports 1..NUM_PORTS (port 0 stays with the ALU).
// Optional: define WB_STARVE_BOOST_EN to add per-unit age counters that boost starved units.
module wb_port_scheduler
    import wb_port_scheduler_pkg::*;
#(
    parameter  int unsigned NUM_UNITS    = WB_SCHED_UNITS,
    parameter  int unsigned NUM_PORTS    = WB_SCHED_PORTS,
    parameter  int unsigned ID_W         = $bits(id_t),
    parameter  int unsigned STARVE_LIMIT = WB_SCHED_STARVE_LIMIT,
    localparam int unsigned SEL_W        = $clog2(NUM_UNITS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_UNITS-1:0]            unit_done,
    input  logic [NUM_UNITS-1:0][ID_W-1:0]  unit_id,
    input  logic [NUM_PORTS-1:0]            port_en,
    output logic [NUM_UNITS-1:0]            unit_ack,
    output logic [NUM_PORTS-1:0]            port_valid,
    output logic [NUM_PORTS-1:0][SEL_W-1:0] port_unit_sel,
    output logic [NUM_PORTS-1:0][ID_W-1:0]  port_id,
    output logic [SEL_W-1:0]                rr_ptr
);

    if (NUM_UNITS < 2 || NUM_PORTS < 1 || NUM_PORTS > NUM_UNITS ||
        ID_W < 1 || STARVE_LIMIT < 1) begin : g_bad_params
        $error("wb_port_scheduler: invalid parameter combination");
    end

    logic [SEL_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [NUM_UNITS-1:0]            grant;
    logic [NUM_PORTS-1:0]            pv;
    logic [NUM_PORTS-1:0][SEL_W-1:0] psel;
    logic                            any_grant;
    logic [SEL_W-1:0]                last_unit;

`ifdef WB_STARVE_BOOST_EN
    localparam int unsigned       AGE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0]  AGE_MAX = AGE_W'(STARVE_LIMIT);

    logic [NUM_UNITS-1:0][AGE_W-1:0] age_q, age_d;
    logic [NUM_UNITS-1:0]            boosted;
    logic [NUM_UNITS-1:0]            grant_b, grant_r;
    logic [NUM_PORTS-1:0]            pv_b, pv_r;
    logic [NUM_PORTS-1:0][SEL_W-1:0] psel_b, psel_r;
    logic                            any_b, any_r;
    logic [SEL_W-1:0]                last_b, last_r;

    always_comb begin
        boosted = '0;
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            boosted[u] = unit_done[u] && (age_q[u] == AGE_MAX);
        end
    end

    // Starved units claim ports first in fixed index order; the rotating scan fills what is left.
    wb_rotate_select #(
        .NUM_UNITS (NUM_UNITS),
        .NUM_PORTS (NUM_PORTS)
    ) u_boost_select (
        .req        (boosted),
        .ptr        ('0),
        .port_mask  (port_en),
        .grant      (grant_b),
        .port_valid (pv_b),
        .port_sel   (psel_b),
        .any_grant  (any_b),
        .last_unit  (last_b)
    );

    wb_rotate_select #(
        .NUM_UNITS (NUM_UNITS),
        .NUM_PORTS (NUM_PORTS)
    ) u_rotate_select (
        .req        (unit_done & ~grant_b),
        .ptr        (rr_ptr_q),
        .port_mask  (port_en & ~pv_b),
        .grant      (grant_r),
        .port_valid (pv_r),
        .port_sel   (psel_r),
        .any_grant  (any_r),
        .last_unit  (last_r)
    );

    // Pointer follows the rotating grants; boosted grants only move it when nothing else won.
    always_comb begin
        grant     = grant_b | grant_r;
        pv        = pv_b | pv_r;
        psel      = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            psel[p] = pv_b[p] ? psel_b[p] : psel_r[p];
        end
        any_grant = any_b | any_r;
        last_unit = any_r ? last_r : last_b;
    end

    always_comb begin
        age_d = age_q;
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            if (!unit_done[u] || unit_ack[u]) begin
                age_d[u] = '0;
            end else if (age_q[u] != AGE_MAX) begin
                age_d[u] = age_q[u] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    wb_rotate_select #(
        .NUM_UNITS (NUM_UNITS),
        .NUM_PORTS (NUM_PORTS)
    ) u_rotate_select (
        .req        (unit_done),
        .ptr        (rr_ptr_q),
        .port_mask  (port_en),
        .grant      (grant),
        .port_valid (pv),
        .port_sel   (psel),
        .any_grant  (any_grant),
        .last_unit  (last_unit)
    );
`endif

    always_comb begin
        unit_ack      = rst ? '0 : grant;
        port_valid    = rst ? '0 : pv;
        port_unit_sel = '0;
        port_id       = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (port_valid[p]) begin
                port_unit_sel[p] = psel[p];
                port_id[p]       = unit_id[psel[p]];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_grant) begin
            rr_ptr_d = SEL_W'(next_unit(32'(last_unit), NUM_UNITS));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed bench for wb_port_scheduler (default build): a queue-based grant model
// checked every cycle, plus hand-computed literal expectations.
module tb_wb_port_scheduler;

    localparam int NU  = 4;
    localparam int NP  = 2;
    localparam int IDW = 3;
    localparam int SW  = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NU-1:0]          unit_done = 4'b1111;
    logic [NU-1:0][IDW-1:0] unit_id;
    logic [NP-1:0]          port_en = 2'b11;
    logic [NU-1:0]          unit_ack;
    logic [NP-1:0]          port_valid;
    logic [NP-1:0][SW-1:0]  port_unit_sel;
    logic [NP-1:0][IDW-1:0] port_id;
    logic [SW-1:0]          rr_ptr;

    int n_checks = 0;
    int n_fail   = 0;

    wb_port_scheduler #(
        .NUM_UNITS    (NU),
        .NUM_PORTS    (NP),
        .ID_W         (IDW),
        .STARVE_LIMIT (7)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .unit_done     (unit_done),
        .unit_id       (unit_id),
        .port_en       (port_en),
        .unit_ack      (unit_ack),
        .port_valid    (port_valid),
        .port_unit_sel (port_unit_sel),
        .port_id       (port_id),
        .rr_ptr        (rr_ptr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: list done units in rotated priority order, list enabled ports ascending,
    // and pair them off; the pointer moves past the last unit that got a port.
    initial begin : model_compare
        int                     mptr;
        int                     nptr;
        int                     n;
        int                     order[$];
        int                     ports[$];
        logic [NU-1:0]          e_ack;
        logic [NP-1:0]          e_pv;
        logic [NP-1:0][SW-1:0]  e_sel;
        logic [NP-1:0][IDW-1:0] e_id;
        mptr = 0;
        forever begin
            @(negedge clk);
            e_ack = '0;
            e_pv  = '0;
            e_sel = '0;
            e_id  = '0;
            nptr  = mptr;
            if (rst) begin
                nptr = 0;
            end else begin
                order.delete();
                ports.delete();
                for (int k = 0; k < NU; k++) begin
                    if (unit_done[(mptr + k) % NU]) order.push_back((mptr + k) % NU);
                end
                for (int p = 0; p < NP; p++) begin
                    if (port_en[p]) ports.push_back(p);
                end
                n = (order.size() < ports.size()) ? order.size() : ports.size();
                for (int i = 0; i < n; i++) begin
                    e_ack[order[i]] = 1'b1;
                    e_pv[ports[i]]  = 1'b1;
                    e_sel[ports[i]] = 2'(order[i]);
                    e_id[ports[i]]  = unit_id[order[i]];
                end
                if (n > 0) nptr = (order[n-1] + 1) % NU;
                check("model rr_ptr", 32'(rr_ptr), 32'(mptr));
            end
            check("model unit_ack", 32'(unit_ack), 32'(e_ack));
            check("model port_valid", 32'(port_valid), 32'(e_pv));
            check("model port_unit_sel", 32'(port_unit_sel), 32'(e_sel));
            check("model port_id", 32'(port_id), 32'(e_id));
            mptr = nptr;
        end
    end

    task automatic step(input logic r, input logic [NU-1:0] d, input logic [NP-1:0] en);
        @(posedge clk);
        #1;
        rst       = r;
        unit_done = d;
        port_en   = en;
        @(negedge clk);
    endtask

    initial begin : stimulus
        logic [NU-1:0] tbl_done [8];
        logic [NP-1:0] tbl_en   [8];
        unit_id = {3'd1, 3'd7, 3'd2, 3'd5};   // unit3=1 unit2=7 unit1=2 unit0=5

        // Reset with every unit pending
        step(1'b1, 4'b1111, 2'b11);
        check("rst ack", 32'(unit_ack), 32'h0);
        check("rst port_valid", 32'(port_valid), 32'h0);
        step(1'b1, 4'b1111, 2'b11);
        check("rst port_id", 32'(port_id), 32'h0);

        // Fairness: all units held done
        step(1'b0, 4'b1111, 2'b11);
        check("fair0 rr_ptr", 32'(rr_ptr), 32'd0);
        check("fair0 ack", 32'(unit_ack), 32'b0011);
        check("fair0 sel", 32'(port_unit_sel), 32'b01_00);
        check("fair0 id", 32'(port_id), 32'b010_101);
        step(1'b0, 4'b1111, 2'b11);
        check("fair1 rr_ptr", 32'(rr_ptr), 32'd2);
        check("fair1 ack", 32'(unit_ack), 32'b1100);
        step(1'b0, 4'b1111, 2'b11);
        check("fair2 rr_ptr", 32'(rr_ptr), 32'd0);
        check("fair2 ack", 32'(unit_ack), 32'b0011);

        // Move pointer to 3, then wrap across the top unit
        step(1'b0, 4'b0100, 2'b11);
        check("pre-wrap ack", 32'(unit_ack), 32'b0100);
        step(1'b0, 4'b1001, 2'b11);
        check("wrap rr_ptr", 32'(rr_ptr), 32'd3);
        check("wrap ack", 32'(unit_ack), 32'b1001);
        check("wrap sel", 32'(port_unit_sel), 32'b00_11);
        check("wrap id", 32'(port_id), 32'b101_001);

        // Pointer 1 -> grant unit3 -> pointer 0, then masked port
        step(1'b0, 4'b1000, 2'b11);
        check("post-wrap rr_ptr", 32'(rr_ptr), 32'd1);
        step(1'b0, 4'b0110, 2'b10);
        check("mask rr_ptr", 32'(rr_ptr), 32'd0);
        check("mask port_valid", 32'(port_valid), 32'b10);
        check("mask ack", 32'(unit_ack), 32'b0010);
        check("mask id", 32'(port_id), 32'b010_000);
        step(1'b0, 4'b0100, 2'b10);
        check("mask2 rr_ptr", 32'(rr_ptr), 32'd2);
        check("mask2 ack", 32'(unit_ack), 32'b0100);

        // All ports masked: nothing granted, pointer holds at 3
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 4'b1111, 2'b00);
            check("noport ack", 32'(unit_ack), 32'h0);
            check("noport rr_ptr", 32'(rr_ptr), 32'd3);
        end

        // Idle
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b0000, 2'b11);
            check("idle ack", 32'(unit_ack), 32'h0);
            check("idle rr_ptr", 32'(rr_ptr), 32'd3);
        end

        // Mixed directed vectors, checked by the model
        unit_id = {3'd6, 3'd3, 3'd0, 3'd4};
        tbl_done = '{4'b1111, 4'b0101, 4'b1010, 4'b0001, 4'b1110, 4'b0111, 4'b1011, 4'b1100};
        tbl_en   = '{2'b01,   2'b11,   2'b11,   2'b11,   2'b01,   2'b11,   2'b10,   2'b11};
        for (int i = 0; i < 8; i++) begin
            step(1'b0, tbl_done[i], tbl_en[i]);
        end

        // Reset mid-burst: pointer parked at 1, then re-arbitration from 0
        step(1'b0, 4'b0001, 2'b11);
        check("pre-rst ack", 32'(unit_ack), 32'b0001);
        step(1'b1, 4'b1111, 2'b11);
        check("midrst ack", 32'(unit_ack), 32'h0);
        step(1'b0, 4'b1111, 2'b11);
        check("postrst rr_ptr", 32'(rr_ptr), 32'd0);
        check("postrst ack", 32'(unit_ack), 32'b0011);
        step(1'b0, 4'b0000, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
